serial_adder_ctrl: RTL

- Bit-serial adder datapath and controller; the sequential stage that drives the existing gate-level fulladder cell one bit per clock.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse, shifts them LSB-first through fulladder, and registers carry between bits.
- Returns a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Area-minimal alternative to a ripple array for slow control paths.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/fulladder.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t : controller state encoding (IDLE, SHIFT, DONE)
//   - SA_WIDTH_DEF : default operand/sum width
package serial_add_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/fulladder.sv
// fulladder
// Gate-level one-bit full adder cell.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = cin & ab_x;
  assign s    = ab_x ^ cin;
  assign cout = ab_a | cx_a;

endmodule : fulladder

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in on an
// accepted start, feeds them LSB-first through one fulladder cell (one bit
// per clock) and returns a registered sum/carry-out with a one-cycle done.
// {cout, sum} = a + b + cin (unsigned, modulo 2^WIDTH for sum).
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   When defined, adds output ovf, the two's-complement overflow flag of
//   the completed addition, registered and held together with sum/cout.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request pulse, sampled only while ready=1
//   a, b   : WIDTH-bit operands, captured on accepted start
//   cin    : carry-in, captured on accepted start
//   ready  : high in IDLE and DONE (a new start is accepted)
//   busy   : high while shifting
//   done   : one-cycle pulse, sum/cout valid
//   sum    : registered result, held until the next completion
//   cout   : registered final carry, held with sum
//   ovf    : (SERIAL_ADD_OVF_EN only) signed overflow, held with sum
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = SA_WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 most recent sum bits; the newest bit from the adder
  // completes the word, so the oldest slot never has to be stored.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_full;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic so;
  logic co;
  logic last_bit;
  logic accept;

  fulladder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (so),
    .cout (co)
  );

  assign sum_full = {so, sum_sr};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // start is only honoured from IDLE or DONE; in SHIFT it is ignored
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE may chain straight into SHIFT with no idle gap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state register
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter.
  // The result registers only update on the edge that consumes the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= sum_full[WIDTH-1:1];
      carry  <= co;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        sum  <= sum_full;
        cout <= co;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the final bit, carry holds the carry into the MSB; overflow is that
  // carry disagreeing with the carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((state == SHIFT) && last_bit) begin
      ovf <= carry ^ co;
    end
  end
`endif

endmodule : serial_adder_ctrl
